move_sequencer: RTL
===================

MOVE_SEQUENCER -- requirements
Module: move_sequencer

Interface
REQ-001 Parameter GEN_TIMEOUT, default 255: max cycles to wait for move_valid after gen_start.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 click  input  1  one-cycle pulse; the mouse selected a square.
REQ-005 click_pos  input  6  clicked square; [5:3] row, [2:0] column.
REQ-006 sq_code  input  4  piece code at query_xy; registered by the board, valid 1 cycle after query_xy changes.
REQ-007 possible_moves  input  64  legal-target mask; bit (63 - (row*8+col)) set = legal.
REQ-008 moves_valid  input  1  one-cycle pulse; possible_moves valid this cycle.
REQ-009 query_xy  output  6  square address driven to the board for sq_code lookup.
REQ-010 pick_piece  output  1  one-cycle pulse; lift the piece at place_pos.
REQ-011 place_piece  output  1  one-cycle pulse; drop the held piece at place_pos.
REQ-012 place_pos  output  6  square for pick_piece/place_piece.
REQ-013 gen_start  output  1  one-cycle pulse; request a move mask for src_pos.
REQ-014 src_pos  output  6  square of the held piece.
REQ-015 white_turn  output  1  1 = white (codes 1-6) to move; 0 = black (codes 7-C).
REQ-016 move_done  output  1  one-cycle pulse after a committed move.
REQ-017 busy  output  1  high in every state except IDLE and SELECTED.

Function
REQ-018 States: IDLE, QUERY, CHECK, PICK, GEN, SELECTED, PLACE.
REQ-019 IDLE: on click, latch click_pos into src_pos and query_xy, then go to QUERY.
REQ-020 QUERY lasts 1 cycle (board latency); go to CHECK.
REQ-021 CHECK: sample sq_code. If it is an own-colour piece (1-6 when white_turn, 7-C otherwise), go to PICK; otherwise (0, opponent piece, D-F) return to IDLE with no output pulse.
REQ-022 PICK: pick_piece=1 and place_pos=src_pos for exactly 1 cycle; then go to GEN.
REQ-023 GEN entry: gen_start pulses 1 cycle and the timeout counter clears.
REQ-024 GEN: on moves_valid, latch possible_moves into the mask register and go to SELECTED.
REQ-025 GEN timeout: if the counter reaches GEN_TIMEOUT first, go to PLACE with place_pos=src_pos (put the piece back); the turn does not change.
REQ-026 SELECTED, click on a square whose mask bit is set: go to PLACE with place_pos=click_pos as a commit.
REQ-027 SELECTED, click on src_pos: go to PLACE with place_pos=src_pos as a cancel, even if the mask bit is set.
REQ-028 SELECTED, any other click: ignored; stay in SELECTED.
REQ-029 PLACE: place_piece=1 for exactly 1 cycle, then IDLE.
REQ-030 PLACE on commit: white_turn toggles and move_done pulses in the same cycle as place_piece.
REQ-031 PLACE on cancel or timeout: no toggle and no move_done.
REQ-032 Clicks arriving while busy=1 are dropped, not queued.
REQ-033 A moves_valid pulse outside GEN is ignored.
REQ-034 pick_piece, place_piece and gen_start are mutually exclusive in every cycle.
REQ-035 Latency click -> pick_piece = 3 cycles (IDLE latch, QUERY, CHECK; pick in the 4th edge).
REQ-036 Latency SELECTED click -> place_piece = 1 cycle.

Reset
REQ-037 On rst: state=IDLE; white_turn=1; all pulse outputs 0; query_xy, place_pos and src_pos = 0; mask=0; counter=0.
REQ-038 Reset during any state, including between pick and place, returns to IDLE immediately; piece restoration is the board's own reset.

Structure
REQ-039 Shared package chess_pkg holds: piece code constants (EMPTY=0, W_PAWN..W_KING=1-6, B_PAWN..B_KING=7-C, MARK=D), the 6-bit square typedef, the state enum, and the mask-index function 63-(row*8+col).
REQ-040 Colour classification is a function in chess_pkg; no sub-module is required.

Verification
REQ-041 Post-reset, click (6,4) with sq_code=1 -> pick_piece at (6,4) 3 cycles later, then gen_start the next cycle; white_turn=1.
REQ-042 In SELECTED with mask bit 27 set, click (4,4) -> place_piece at pos 36, move_done=1, white_turn=0 in the same cycle.
REQ-043 White's turn, click a square with sq_code=7 -> no pick_piece; back to IDLE after CHECK.
REQ-044 In SELECTED, click src_pos -> place_piece at src_pos; white_turn unchanged; no move_done.
REQ-045 GEN with no moves_valid for 255 cycles -> place_piece at src_pos; state IDLE.
REQ-046 Assert rst in the cycle after pick_piece -> all outputs 0, white_turn=1, and the next click is accepted normally.

Source files
------------

// File: rtl/chess_pkg.sv
// Shared chess definitions: piece codes, square type, sequencer states,
// mask indexing and colour classification.
package chess_pkg;

  localparam int unsigned SQ_W   = 6;
  localparam int unsigned CODE_W = 4;
  localparam int unsigned MASK_W = 64;

  typedef logic [SQ_W-1:0]   square_t;
  typedef logic [CODE_W-1:0] code_t;
  typedef logic [MASK_W-1:0] mask_t;

  typedef enum logic [3:0] {
    EMPTY    = 4'h0,
    W_PAWN   = 4'h1,
    W_KNIGHT = 4'h2,
    W_BISHOP = 4'h3,
    W_ROOK   = 4'h4,
    W_QUEEN  = 4'h5,
    W_KING   = 4'h6,
    B_PAWN   = 4'h7,
    B_KNIGHT = 4'h8,
    B_BISHOP = 4'h9,
    B_ROOK   = 4'hA,
    B_QUEEN  = 4'hB,
    B_KING   = 4'hC,
    MARK     = 4'hD
  } piece_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_QUERY,
    S_CHECK,
    S_PICK,
    S_GEN,
    S_SELECTED,
    S_PLACE
  } state_e;

  // Board masks are MSB-first: square (0,0) is bit 63.
  function automatic logic [5:0] mask_idx(input square_t sq);
    return 6'(7'd63 - 7'({sq[5:3], 3'b000}) - 7'(sq[2:0]));
  endfunction

  function automatic logic is_own_piece(input code_t code, input logic white);
    if (white) return (code >= 4'(W_PAWN)) && (code <= 4'(W_KING));
    else       return (code >= 4'(B_PAWN)) && (code <= 4'(B_KING));
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Mouse/board/move-generator signal bundle for the move sequencer.
interface move_sequencer_if;
  import chess_pkg::*;

  logic    click;
  square_t click_pos;
  code_t   sq_code;
  mask_t   possible_moves;
  logic    moves_valid;
  square_t query_xy;
  logic    pick_piece;
  logic    place_piece;
  square_t place_pos;
  logic    gen_start;
  square_t src_pos;
  logic    white_turn;
  logic    move_done;
  logic    busy;

  modport master (
    input  click, click_pos, sq_code, possible_moves, moves_valid,
    output query_xy, pick_piece, place_piece, place_pos, gen_start,
           src_pos, white_turn, move_done, busy
  );

  modport slave (
    output click, click_pos, sq_code, possible_moves, moves_valid,
    input  query_xy, pick_piece, place_piece, place_pos, gen_start,
           src_pos, white_turn, move_done, busy
  );

endinterface

// File: rtl/move_sequencer.sv
// Turns mouse clicks into pick / generate / place sequences against the board
// and move generator, tracking whose turn it is.
module move_sequencer
  import chess_pkg::*;
#(
  parameter int unsigned GEN_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  move_sequencer_if.master bus
);

  localparam int unsigned CNT_W = $clog2(GEN_TIMEOUT + 1);

  state_e           state_q, state_d;
  square_t          query_xy_q, query_xy_d;
  square_t          src_pos_q, src_pos_d;
  square_t          place_pos_q, place_pos_d;
  mask_t            mask_q, mask_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pick_q, pick_d;
  logic             place_q, place_d;
  logic             gen_q, gen_d;
  logic             done_q, done_d;
  logic             white_q, white_d;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      query_xy_q  <= '0;
      src_pos_q   <= '0;
      place_pos_q <= '0;
      mask_q      <= '0;
      cnt_q       <= '0;
      pick_q      <= 1'b0;
      place_q     <= 1'b0;
      gen_q       <= 1'b0;
      done_q      <= 1'b0;
      white_q     <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      query_xy_q  <= query_xy_d;
      src_pos_q   <= src_pos_d;
      place_pos_q <= place_pos_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      pick_q      <= pick_d;
      place_q     <= place_d;
      gen_q       <= gen_d;
      done_q      <= done_d;
      white_q     <= white_d;
      busy_q      <= busy_d;
    end
  end

  // Pulse outputs are computed on the transition so they appear together
  // with the state they belong to.
  always_comb begin
    state_d     = state_q;
    query_xy_d  = query_xy_q;
    src_pos_d   = src_pos_q;
    place_pos_d = place_pos_q;
    mask_d      = mask_q;
    cnt_d       = cnt_q;
    pick_d      = 1'b0;
    place_d     = 1'b0;
    gen_d       = 1'b0;
    done_d      = 1'b0;
    white_d     = white_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.click) begin
          query_xy_d = bus.click_pos;
          src_pos_d  = bus.click_pos;
          state_d    = S_QUERY;
        end
      end
      S_QUERY: state_d = S_CHECK;
      S_CHECK: begin
        if (is_own_piece(bus.sq_code, white_q)) begin
          state_d     = S_PICK;
          pick_d      = 1'b1;
          place_pos_d = src_pos_q;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_PICK: begin
        state_d = S_GEN;
        gen_d   = 1'b1;
        cnt_d   = '0;
      end
      S_GEN: begin
        if (bus.moves_valid) begin
          mask_d  = bus.possible_moves;
          state_d = S_SELECTED;
        end else if (cnt_q == CNT_W'(GEN_TIMEOUT - 1)) begin
          // No answer from the generator: put the piece back, turn unchanged.
          cnt_d       = cnt_q + CNT_W'(1);
          state_d     = S_PLACE;
          place_d     = 1'b1;
          place_pos_d = src_pos_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_SELECTED: begin
        if (bus.click) begin
          if (bus.click_pos == src_pos_q) begin
            state_d     = S_PLACE;
            place_d     = 1'b1;
            place_pos_d = src_pos_q;
          end else if (mask_q[mask_idx(bus.click_pos)]) begin
            state_d     = S_PLACE;
            place_d     = 1'b1;
            place_pos_d = bus.click_pos;
            done_d      = 1'b1;
            white_d     = ~white_q;
          end
        end
      end
      S_PLACE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = !((state_d == S_IDLE) || (state_d == S_SELECTED));
  end

  assign bus.query_xy    = query_xy_q;
  assign bus.src_pos     = src_pos_q;
  assign bus.place_pos   = place_pos_q;
  assign bus.pick_piece  = pick_q;
  assign bus.place_piece = place_q;
  assign bus.gen_start   = gen_q;
  assign bus.move_done   = done_q;
  assign bus.white_turn  = white_q;
  assign bus.busy        = busy_q;

endmodule
